// File: rtl/packet_write_scheduler.sv
// Merges two packetised word sources onto one FIFO write port. Each packet is
// framed by a header word and an end flag, and FIFO space is reserved so no word is ever dropped.
module packet_write_scheduler #(
    parameter int          FIFO_DEPTH    = 256,
    parameter int          MAX_PKT_WORDS = 64,
    parameter logic [7:0]  HEADER_MAGIC  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        s0_valid,
    input  logic [31:0] s0_data,
    input  logic        s0_last,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [31:0] s1_data,
    input  logic        s1_last,
    output logic        s1_ready,
    output logic        fifo_write_en,
    output logic [31:0] fifo_write_data,
    output logic        fifo_packet_end_flag,
    input  logic [8:0]  fifo_count,
    output logic        busy,
    output logic        active_src,
    output logic [15:0] seq_num,
    output logic        overlength_err
);

    localparam logic [9:0] DEPTH_W  = 10'(FIFO_DEPTH);
    localparam logic [7:0] LAST_IDX = 8'(MAX_PKT_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DRAIN
    } state_t;

    state_t      state_reg;
    logic        grant_reg;
    logic        last_grant_reg;
    logic [15:0] seq_reg;
    logic [7:0]  word_cnt_reg;
    logic        ovl_reg;
    logic        wr_en_reg;
    logic [31:0] wr_data_reg;
    logic        wr_flag_reg;
    logic        pend_d2_reg;

    logic [1:0]  src_valid_vec;
    logic [1:0]  src_last_vec;
    logic [31:0] src_data_vec [2];
    logic [1:0]  ready_vec;

    logic        g_valid;
    logic        g_last;
    logic [31:0] g_data;
    logic        pkt_end;
    logic [1:0]  pend;
    logic [9:0]  space_need;
    logic        space_ok;
    logic        accept_window;
    logic        pref_src;
    logic        pick_src;

    assign src_valid_vec   = {s1_valid, s0_valid};
    assign src_last_vec    = {s1_last, s0_last};
    assign src_data_vec[0] = s0_data;
    assign src_data_vec[1] = s1_data;

    assign g_valid = src_valid_vec[grant_reg];
    assign g_last  = src_last_vec[grant_reg];
    assign g_data  = src_data_vec[grant_reg];
    assign pkt_end = g_last || (word_cnt_reg == LAST_IDX);

    // Words decided in the last two cycles are not yet reflected in fifo_count.
    assign pend       = {1'b0, wr_en_reg} + {1'b0, pend_d2_reg};
    assign space_need = {1'b0, fifo_count} + {8'b0, pend} + 10'd1;
    assign space_ok   = (space_need <= DEPTH_W);

    // Ready is decoded from registered state so a stall takes effect in the same cycle
    // that space runs out; it is forced low while reset is held.
    assign accept_window = ((state_reg == PAYLOAD) && space_ok) || (state_reg == DRAIN);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = !rst && accept_window && (grant_reg == 1'(gi));
        end
    endgenerate

    assign s0_ready = ready_vec[0];
    assign s1_ready = ready_vec[1];

    assign pref_src = ~last_grant_reg;
    assign pick_src = src_valid_vec[pref_src] ? pref_src : last_grant_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            seq_reg        <= 16'd0;
            word_cnt_reg   <= 8'd0;
            ovl_reg        <= 1'b0;
            wr_en_reg      <= 1'b0;
            wr_data_reg    <= 32'd0;
            wr_flag_reg    <= 1'b0;
            pend_d2_reg    <= 1'b0;
        end else begin
            wr_en_reg   <= 1'b0;
            wr_flag_reg <= 1'b0;
            pend_d2_reg <= wr_en_reg;
            case (state_reg)
                IDLE: begin
                    if (enable && (s0_valid || s1_valid)) begin
                        grant_reg      <= pick_src;
                        last_grant_reg <= pick_src;
                        state_reg      <= HEADER;
                    end
                end
                HEADER: begin
                    if (space_ok) begin
                        wr_en_reg    <= 1'b1;
                        wr_data_reg  <= {HEADER_MAGIC, 6'b0, 1'b0, grant_reg, seq_reg};
                        word_cnt_reg <= 8'd0;
                        state_reg    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (g_valid && space_ok) begin
                        wr_en_reg    <= 1'b1;
                        wr_data_reg  <= g_data;
                        word_cnt_reg <= word_cnt_reg + 8'd1;
                        if (pkt_end) begin
                            wr_flag_reg <= 1'b1;
                            seq_reg     <= seq_reg + 16'd1;
                            // A packet cut at the length limit still needs its tail swallowed.
                            if (!g_last) begin
                                ovl_reg   <= 1'b1;
                                state_reg <= DRAIN;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (g_valid && g_last) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign fifo_write_en        = wr_en_reg;
    assign fifo_write_data      = wr_data_reg;
    assign fifo_packet_end_flag = wr_flag_reg;
    assign busy                 = (state_reg != IDLE);
    assign active_src           = grant_reg;
    assign seq_num              = seq_reg;
    assign overlength_err       = ovl_reg;

endmodule

// File: tb/tb_packet_write_scheduler.sv
// Randomised bench for packet_write_scheduler: sources and a downstream FIFO are
// modelled as queues, and the expected write stream is built per packet from the framing rules.
module tb_packet_write_scheduler;

    localparam int DEPTH = 256;
    localparam int MAXW  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        s0_valid, s0_last, s0_ready;
    logic        s1_valid, s1_last, s1_ready;
    logic [31:0] s0_data, s1_data;
    logic        fifo_write_en;
    logic [31:0] fifo_write_data;
    logic        fifo_packet_end_flag;
    logic [8:0]  fifo_count;
    logic        busy;
    logic        active_src;
    logic [15:0] seq_num;
    logic        overlength_err;

    always #5 clk = ~clk;

    packet_write_scheduler #(
        .FIFO_DEPTH    (DEPTH),
        .MAX_PKT_WORDS (MAXW),
        .HEADER_MAGIC  (8'hA5)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable               (enable),
        .s0_valid             (s0_valid),
        .s0_data              (s0_data),
        .s0_last              (s0_last),
        .s0_ready             (s0_ready),
        .s1_valid             (s1_valid),
        .s1_data              (s1_data),
        .s1_last              (s1_last),
        .s1_ready             (s1_ready),
        .fifo_write_en        (fifo_write_en),
        .fifo_write_data      (fifo_write_data),
        .fifo_packet_end_flag (fifo_packet_end_flag),
        .fifo_count           (fifo_count),
        .busy                 (busy),
        .active_src           (active_src),
        .seq_num              (seq_num),
        .overlength_err       (overlength_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Source queues hold {last, data}; expected queues hold {flag, data}.
    logic [32:0] src_q0[$];
    logic [32:0] src_q1[$];
    logic [32:0] exp_q[$];
    logic [32:0] held_q[$];
    logic [15:0] exp_seq = 16'd0;
    bit          exp_ovl = 1'b0;

    bit hs0 = 1'b0, hs1 = 1'b0;
    bit first0 = 1'b1, first1 = 1'b1;
    bit wr_h1 = 1'b0, wr_h2 = 1'b0;
    int occ = 0;
    int cyc = 0;
    int n_writes = 0;
    int first_wr_cyc = 0;
    int last_wr_cyc = 0;
    logic [31:0] first_wr_data = 32'd0;

    int unsigned gap_pct   = 0;
    int unsigned drain_pct = 100;
    int unsigned en_pct    = 100;

    task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic add_packet(input int s, input int len, input bit hold);
        logic [31:0] w;
        logic [32:0] e;
        logic        sb;
        sb = s[0];
        e  = {1'b0, 8'hA5, 6'd0, 1'b0, sb, exp_seq};
        if (hold) held_q.push_back(e); else exp_q.push_back(e);
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            if (s == 0) src_q0.push_back({(i == len - 1), w});
            else        src_q1.push_back({(i == len - 1), w});
            if (i < MAXW) begin
                e = {((i == len - 1) || (i == MAXW - 1)), w};
                if (hold) held_q.push_back(e); else exp_q.push_back(e);
            end
        end
        exp_seq = exp_seq + 16'd1;
        if (len > MAXW) exp_ovl = 1'b1;
    endtask

    task automatic step();
        logic [32:0] tmp;
        @(negedge clk);
        if (hs0) tmp = src_q0.pop_front();
        if (hs1) tmp = src_q1.pop_front();
        // A write seen in cycle c is reflected in fifo_count from cycle c+2.
        occ = occ + int'(wr_h2);
        if (wr_h2) check_eq("fifo_overflow", 33'(occ <= DEPTH), 33'd1);
        if (occ > 0 && $urandom_range(99) < drain_pct) occ = occ - 1;
        fifo_count = 9'(occ);
        if (src_q0.size() > 0) begin
            s0_valid = first0 || ($urandom_range(99) >= gap_pct);
            s0_data  = src_q0[0][31:0];
            s0_last  = src_q0[0][32];
        end else begin
            s0_valid = 1'b0;
            s0_data  = $urandom;
            s0_last  = 1'b0;
        end
        if (src_q1.size() > 0) begin
            s1_valid = first1 || ($urandom_range(99) >= gap_pct);
            s1_data  = src_q1[0][31:0];
            s1_last  = src_q1[0][32];
        end else begin
            s1_valid = 1'b0;
            s1_data  = $urandom;
            s1_last  = 1'b0;
        end
        enable = ($urandom_range(99) < en_pct);
        #1;
        if (fifo_write_en) begin
            if (n_writes == 0) begin
                first_wr_cyc  = cyc;
                first_wr_data = fifo_write_data;
            end
            last_wr_cyc = cyc;
            n_writes++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_write", 33'(fifo_write_en), 33'd0);
            end else begin
                tmp = exp_q.pop_front();
                check_eq("wr_data", 33'(fifo_write_data), 33'(tmp[31:0]));
                check_eq("wr_flag", 33'(fifo_packet_end_flag), 33'(tmp[32]));
            end
        end
        check_eq("ready_exclusive", 33'(s0_ready & s1_ready), 33'd0);
        hs0 = s0_valid && s0_ready;
        hs1 = s1_valid && s1_ready;
        if (hs0) first0 = src_q0[0][32];
        if (hs1) first1 = src_q1[0][32];
        wr_h2 = wr_h1;
        wr_h1 = fifo_write_en;
        cyc++;
    endtask

    task automatic run_until_done(input int max_cyc);
        int i;
        i = 0;
        while (i < max_cyc && (exp_q.size() != 0 || src_q0.size() != 0 || src_q1.size() != 0)) begin
            step();
            i++;
        end
        for (int k = 0; k < 3; k++) step();
        check_eq("done_exp_left", 33'(exp_q.size()), 33'd0);
        check_eq("done_src_left", 33'(src_q0.size() + src_q1.size()), 33'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        s0_valid   = 1'b0;
        s1_valid   = 1'b0;
        enable     = 1'b0;
        fifo_count = 9'd0;
        @(negedge clk);
        #1;
        check_eq("rst_wr_en", 33'(fifo_write_en), 33'd0);
        check_eq("rst_wr_data", 33'(fifo_write_data), 33'd0);
        check_eq("rst_flag", 33'(fifo_packet_end_flag), 33'd0);
        check_eq("rst_busy", 33'(busy), 33'd0);
        check_eq("rst_active_src", 33'(active_src), 33'd0);
        check_eq("rst_seq", 33'(seq_num), 33'd0);
        check_eq("rst_ovl", 33'(overlength_err), 33'd0);
        check_eq("rst_ready", 33'({s1_ready, s0_ready}), 33'd0);
        rst = 1'b0;
        src_q0.delete();
        src_q1.delete();
        exp_q.delete();
        held_q.delete();
        hs0 = 1'b0; hs1 = 1'b0;
        first0 = 1'b1; first1 = 1'b1;
        wr_h1 = 1'b0; wr_h2 = 1'b0;
        occ = 0;
        exp_seq = 16'd0;
        exp_ovl = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0;
        s0_valid = 1'b0; s0_data = 32'd0; s0_last = 1'b0;
        s1_valid = 1'b0; s1_data = 32'd0; s1_last = 1'b0;
        fifo_count = 9'd0;

        // Single 3-word packet from source 0 into an empty FIFO.
        do_reset();
        gap_pct = 0; drain_pct = 100; en_pct = 100;
        n_writes = 0;
        add_packet(0, 3, 1'b0);
        run_until_done(50);
        check_eq("t1_writes", 33'(n_writes), 33'd4);
        check_eq("t1_consecutive", 33'(last_wr_cyc - first_wr_cyc), 33'd3);
        check_eq("t1_header", 33'(first_wr_data), 33'h0A500_0000);
        check_eq("t1_seq", 33'(seq_num), 33'd1);
        $display("[TB] single packet: %0d writes", n_writes);

        // Both sources contending: strict alternation, sequence 0..3.
        do_reset();
        add_packet(0, 2, 1'b0);
        add_packet(1, 2, 1'b0);
        add_packet(0, 2, 1'b0);
        add_packet(1, 2, 1'b0);
        run_until_done(100);
        check_eq("t2_seq", 33'(seq_num), 33'd4);
        check_eq("t2_ovl_clear", 33'(overlength_err), 33'd0);
        $display("[TB] alternation: seq_num=%0d", seq_num);

        // Overlength packet from source 1 is cut at MAXW words and its tail drained.
        add_packet(1, 6, 1'b0);
        run_until_done(100);
        check_eq("t3_ovl_set", 33'(overlength_err), 33'd1);
        add_packet(0, 2, 1'b0);
        run_until_done(100);
        check_eq("t3_ovl_sticky", 33'(overlength_err), 33'd1);
        check_eq("t3_seq", 33'(seq_num), 33'd6);
        $display("[TB] truncation: overlength_err=%0b seq_num=%0d", overlength_err, seq_num);

        // Enable dropped mid-packet: packet finishes, nothing new until enable returns.
        gap_pct = 40;
        add_packet(0, 4, 1'b0);
        step();
        step();
        en_pct = 0;
        add_packet(1, 3, 1'b1);
        for (int i = 0; i < 40; i++) step();
        check_eq("t4_pkt_done", 33'(exp_q.size()), 33'd0);
        check_eq("t4_idle", 33'(busy), 33'd0);
        foreach (held_q[i]) exp_q.push_back(held_q[i]);
        held_q.delete();
        en_pct = 100;
        step();
        check_eq("t4_lat0", 33'(fifo_write_en), 33'd0);
        step();
        check_eq("t4_lat1", 33'(fifo_write_en), 33'd0);
        step();
        check_eq("t4_lat2", 33'(fifo_write_en), 33'd1);
        run_until_done(200);
        $display("[TB] enable gating: seq_num=%0d", seq_num);

        // FIFO never drains: writes must stop exactly at full.
        do_reset();
        gap_pct = 0; drain_pct = 0; en_pct = 100;
        for (int p = 0; p < 40; p++) begin
            add_packet(0, 3 + int'($urandom_range(1)), 1'b0);
            add_packet(1, 3 + int'($urandom_range(1)), 1'b0);
        end
        for (int i = 0; i < 500; i++) step();
        check_eq("t5_fill_level", 33'(occ), 33'(DEPTH));
        check_eq("t5_stalled_wr", 33'(fifo_write_en), 33'd0);
        check_eq("t5_stalled_ready", 33'({s1_ready, s0_ready}), 33'd0);
        drain_pct = 70;
        run_until_done(3000);
        $display("[TB] backpressure: fill level reached %0d", DEPTH);

        // Randomised traffic with gaps, drain jitter and enable toggling.
        do_reset();
        gap_pct = 30; drain_pct = 50; en_pct = 80;
        for (int p = 0; p < 30; p++) begin
            add_packet(0, 1 + int'($urandom_range(5)), 1'b0);
            add_packet(1, 1 + int'($urandom_range(5)), 1'b0);
        end
        run_until_done(8000);
        check_eq("t6_ovl", 33'(overlength_err), 33'(exp_ovl));
        check_eq("t6_seq", 33'(seq_num), 33'(exp_seq));
        $display("[TB] random traffic: seq_num=%0d overlength_err=%0b", seq_num, overlength_err);

        // Reset in the middle of a source 0 packet; first grant afterwards is source 0 again.
        gap_pct = 50; drain_pct = 100; en_pct = 100;
        add_packet(0, 4, 1'b0);
        step();
        step();
        step();
        check_eq("t7_busy", 33'(busy), 33'd1);
        check_eq("t7_active", 33'(active_src), 33'd0);
        do_reset();
        gap_pct = 0;
        n_writes = 0;
        add_packet(0, 2, 1'b0);
        add_packet(1, 2, 1'b0);
        run_until_done(100);
        check_eq("t7_first_header", 33'(first_wr_data), 33'h0A500_0000);
        check_eq("t7_seq", 33'(seq_num), 33'd2);
        $display("[TB] mid-packet reset: first header %h", first_wr_data);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_write_scheduler.md
Name: packet_write_scheduler

Overview:
- Arbitrates two word-streaming sources (e.g. Intan sample packer and auxiliary/timestamp source) into the single write port of the FIFO-to-BRAM interface.
- Packets are atomic: one source owns the port from header to packet end.
- Prepends a header word to each packet and drives the packet-end flag on the last word.
- Throttles on FIFO occupancy, accounting for the two-cycle write pipeline, so no word is ever dropped.

Parameters:
- FIFO_DEPTH, 256, entry count of the downstream FIFO (must match downstream).
- MAX_PKT_WORDS, 64, max payload words per packet, excluding header; range 1..255.
- HEADER_MAGIC, 8'hA5, header bits [31:24].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  1 = accept new packets; 0 = finish the current packet, then idle.
- s0_valid  in  1  source 0 word valid.
- s0_data  in  32  source 0 word.
- s0_last  in  1  source 0 last payload word of packet.
- s0_ready  out  1  source 0 word accepted when valid&&ready.
- s1_valid, s1_data, s1_last, s1_ready  same as s0, for source 1.
- fifo_write_en  out  1  write strobe to FIFO interface.
- fifo_write_data  out  32  write word.
- fifo_packet_end_flag  out  1  marks last word of packet; valid with fifo_write_en.
- fifo_count  in  9  downstream FIFO occupancy.
- busy  out  1  state != IDLE.
- active_src  out  1  source currently granted (last granted when idle).
- seq_num  out  16  sequence number of the next packet header.
- overlength_err  out  1  sticky; a source exceeded MAX_PKT_WORDS.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0; state=IDLE; seq_num=0; last_grant=1 (source 0 wins the first arbitration); pending-write history cleared. Mid-packet reset abandons the packet with no end flag; the downstream block is reset by the system at the same time.
- Space check: `pend` = number of words issued in the previous two cycles (0..2). space_ok = (fifo_count + pend + 1 <= FIFO_DEPTH), computed at 10-bit width.
- Output timing: all outputs are registered. A word decided in cycle t appears on fifo_write_en/data/flag in t+1 for exactly one cycle. fifo_write_en=0 whenever no word is decided.
- IDLE:
  - if enable && (s0_valid || s1_valid): grant round-robin. Prefer !last_grant if it is valid, else the other. Latch the grant, update last_grant, go to HEADER.
  - s*_ready=0.
- HEADER:
  - when space_ok, emit {HEADER_MAGIC, 6'b0, 1'b0, grant, seq_num}, flag=0; word_cnt=0; go to PAYLOAD.
  - otherwise hold.
- PAYLOAD:
  - s_grant_ready = space_ok; ungranted ready = 0.
  - On handshake: emit the data word; word_cnt++.
  - flag = s_last || (word_cnt == MAX_PKT_WORDS-1).
  - On flag: seq_num++ (wraps 16'hFFFF->0).
    - If truncated (not s_last): set overlength_err and go to DRAIN.
    - Else go to IDLE.
- DRAIN: granted ready=1, words discarded (no FIFO writes). On a handshake with last, go to IDLE.
- enable only gates the IDLE->HEADER transition; deasserting mid-packet has no effect on that packet.
- Both sources valid in the same cycle: strict alternation across packets.
- A header with no payload is impossible: HEADER waits for nothing, and PAYLOAD waits for valid. A source stalling mid-packet holds the port indefinitely; there is no timeout.
- A single-word packet (last on the first word) produces header + 1 word with the flag on word 2.
- Throughput: up to 1 word/cycle while space_ok. Each packet costs 1 IDLE cycle and 1 HEADER cycle of overhead.

Test Plan:
- Reset, then s0 sends 3 words (last on the 3rd), fifo_count=0 -> 4 writes on consecutive cycles:
  - word 1 = 32'hA500_0000;
  - words 2-4 = payload;
  - flag only on word 4;
  - seq_num becomes 1.
- s0 and s1 both valid continuously, 2-word packets -> headers alternate src 0,1,0,1; bits [15:0] = 0,1,2,3; packets never interleave.
- fifo_count held at FIFO_DEPTH-2 = 254 during PAYLOAD -> at most 2 words issued with pend accounting, then s0_ready=0 until fifo_count drops. The sum of fifo_count plus outstanding writes never exceeds 256.
- MAX_PKT_WORDS=4, s1 sends 6 words -> header + 4 words written with flag on the 4th; words 5-6 accepted and discarded; overlength_err=1 and stays 1; next header seq incremented once.
- enable dropped mid-packet -> current packet completes with flag; no new header while enable=0; the next packet starts 2 cycles after enable returns with a pending valid.
- rst asserted during PAYLOAD -> next cycle all outputs 0, seq_num=0; the first packet after reset is granted to source 0.
